// File: rtl/fc_pingpong_if.sv
// rtl/fc_pingpong_if.sv - writer, dense-layer and status signals of the ping-pong feature store
interface fc_pingpong_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1568
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  dense_start;
  logic                  dense_done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [15:0]           frames_done;
  logic                  err_overflow;
  logic                  err_protocol;

  modport master (
    output wr_en, wr_addr, wr_data, wr_last, dense_done, rd_en, rd_addr,
    input  wr_ready, dense_start, rd_q, frames_done, err_overflow, err_protocol
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_last, dense_done, rd_en, rd_addr,
    output wr_ready, dense_start, rd_q, frames_done, err_overflow, err_protocol
  );
endinterface

// File: rtl/fc_pingpong_ctrl.sv
// rtl/fc_pingpong_ctrl.sv - double-buffered feature store and dense-layer scheduler
module fc_pingpong_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1568
) (
  input  logic          clk,
  input  logic          reset,
  fc_pingpong_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_e;
  typedef enum logic {R_IDLE, R_WAIT} rd_state_e;

  bank_e                 bank_q [2];
  logic                  wbank_q;
  logic                  rbank_q;
  rd_state_e             rstate_q;
  logic                  dense_start_q;
  logic [DATA_WIDTH-1:0] rd_q_q;
  logic [15:0]           frames_q;
  logic                  err_ovf_q;
  logic                  err_prot_q;

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic wr_ready;
  logic wr_addr_ok;
  logic rd_addr_ok;
  logic wr_accept;

  assign wr_ready   = (bank_q[wbank_q] == B_EMPTY) || (bank_q[wbank_q] == B_FILLING);
  assign wr_addr_ok = {1'b0, bus.wr_addr} < DEPTH_C;
  assign rd_addr_ok = {1'b0, bus.rd_addr} < DEPTH_C;
  assign wr_accept  = bus.wr_en && wr_ready && wr_addr_ok;

  // Writer and reader always touch different banks, so both updates may land on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]     <= B_EMPTY;
      bank_q[1]     <= B_EMPTY;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      rstate_q      <= R_IDLE;
      dense_start_q <= 1'b0;
      frames_q      <= 16'd0;
      err_ovf_q     <= 1'b0;
      err_prot_q    <= 1'b0;
    end else begin
      dense_start_q <= 1'b0;

      if (wr_accept) begin
        if (bus.wr_last) begin
          bank_q[wbank_q] <= B_FULL;
          wbank_q         <= ~wbank_q;
        end else if (bank_q[wbank_q] == B_EMPTY) begin
          bank_q[wbank_q] <= B_FILLING;
        end
      end else if (bus.wr_en) begin
        err_ovf_q <= 1'b1;
      end

      if (rstate_q == R_IDLE) begin
        if (bank_q[rbank_q] == B_FULL) begin
          bank_q[rbank_q] <= B_READING;
          dense_start_q   <= 1'b1;
          rstate_q        <= R_WAIT;
        end
        if (bus.dense_done) begin
          err_prot_q <= 1'b1;
        end
      end else if (bus.dense_done) begin
        bank_q[rbank_q] <= B_EMPTY;
        rbank_q         <= ~rbank_q;
        frames_q        <= frames_q + 16'd1;
        rstate_q        <= R_IDLE;
      end
    end
  end

  // Storage is left uncleared by reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wbank_q][bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_q <= '0;
    end else if (bus.rd_en) begin
      rd_q_q <= rd_addr_ok ? mem_q[rbank_q][bus.rd_addr] : '0;
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.dense_start  = dense_start_q;
  assign bus.rd_q         = rd_q_q;
  assign bus.frames_done  = frames_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_protocol = err_prot_q;
endmodule

// File: tb/tb_fc_pingpong_ctrl.sv
// tb/tb_fc_pingpong_ctrl.sv - randomized bench for fc_pingpong_ctrl with a frame-level reference model
module tb_fc_pingpong_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 1568;
  localparam int AW    = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fc_pingpong_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  fc_pingpong_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int passed = 0;

  // Model: frames held (complete, not yet consumed), whether the dense layer owns one,
  // which bank the writer fills next and which bank holds the oldest held frame.
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_occ = 0;
  bit            m_reading = 0;
  bit            m_wb = 0;
  bit            m_rb = 0;
  logic [15:0]   m_frames = 0;
  bit            m_ovf = 0;
  bit            m_prot = 0;
  logic          m_start = 0;
  logic [DW-1:0] m_rd = 0;

  function automatic logic [DW-1:0] gen(input int mode, input int a);
    case (mode)
      0:       return DW'(a);
      1:       return DW'(a + 100);
      default: return DW'($urandom_range(0, 16'hDEAC));
    endcase
  endfunction

  task automatic step(input bit rst, input bit wen, input int addr, input logic [DW-1:0] data,
                      input bit last, input bit done, input bit ren, input int raddr);
    int occ_pre;
    bit reading_pre;
    reset = rst;
    bus.wr_en = wen;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    bus.wr_last = last;
    bus.dense_done = done;
    bus.rd_en = ren;
    bus.rd_addr = AW'(raddr);
    @(posedge clk);
    occ_pre = m_occ;
    reading_pre = m_reading;
    if (rst) begin
      m_occ = 0; m_reading = 0; m_wb = 0; m_rb = 0; m_frames = 0;
      m_ovf = 0; m_prot = 0; m_start = 0; m_rd = 0;
    end else begin
      m_start = 0;
      if (ren) m_rd = (raddr < DEPTH) ? m_mem[m_rb][raddr] : '0;
      if (wen) begin
        if (occ_pre < 2 && addr < DEPTH) begin
          m_mem[m_wb][addr] = data;
          if (last) begin m_occ++; m_wb = !m_wb; end
        end else begin
          m_ovf = 1;
        end
      end
      if (done && !reading_pre) m_prot = 1;
      if (!reading_pre && occ_pre > 0) begin
        m_reading = 1; m_start = 1;
      end else if (reading_pre && done) begin
        m_reading = 0; m_occ--; m_rb = !m_rb; m_frames++;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic write_words(input int first, input int last_addr, input int mode, input bit with_last);
    for (int a = first; a <= last_addr; a++)
      step(0, 1, a, gen(mode, a), with_last && (a == last_addr), 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); else passed++;
    total++; if (bus.dense_start !== 1'b0) $display("FAIL reset_dense_start got %b want 0", bus.dense_start); else passed++;
    total++; if (bus.rd_q !== 16'd0) $display("FAIL reset_rd_q got %0h want 0", bus.rd_q); else passed++;
    total++; if (bus.frames_done !== 16'd0) $display("FAIL reset_frames got %0d want 0", bus.frames_done); else passed++;
    total++; if ({bus.err_overflow, bus.err_protocol} !== 2'b00)
      $display("FAIL reset_errors got %b want 00", {bus.err_overflow, bus.err_protocol}); else passed++;
    step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_fill_and_start();
    write_words(0, DEPTH - 1, 0, 1);
    total++; if (bus.dense_start !== 1'b0) $display("FAIL fill_start_early got %b want 0", bus.dense_start); else passed++;
    idle();
    total++; if (bus.dense_start !== 1'b1) $display("FAIL fill_start_pulse got %b want 1", bus.dense_start); else passed++;
    step(0, 0, 0, '0, 0, 0, 1, 5);
    total++; if (bus.dense_start !== 1'b0) $display("FAIL fill_start_width got %b want 0", bus.dense_start); else passed++;
    total++; if (bus.rd_q !== 16'd5) $display("FAIL fill_read5 got %0d want 5", bus.rd_q); else passed++;
  endtask

  task automatic test_overlap();
    int drops = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (bus.wr_ready !== 1'b1) drops++;
      step(0, 1, a, gen(1, a), a == DEPTH - 1, 0, 0, 0);
    end
    total++; if (drops != 0) $display("FAIL overlap_ready_drops got %0d want 0", drops); else passed++;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL overlap_both_full got %b want 0", bus.wr_ready); else passed++;
    step(0, 0, 0, '0, 0, 1, 0, 0);
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL overlap_freed got %b want 1", bus.wr_ready); else passed++;
    total++; if (bus.dense_start !== 1'b0) $display("FAIL overlap_start_early got %b want 0", bus.dense_start); else passed++;
    total++; if (bus.frames_done !== 16'd1) $display("FAIL overlap_frames got %0d want 1", bus.frames_done); else passed++;
    step(0, 0, 0, '0, 0, 0, 1, 5);
    total++; if (bus.dense_start !== 1'b1) $display("FAIL overlap_start got %b want 1", bus.dense_start); else passed++;
    idle();
    total++; if (bus.rd_q !== 16'd105) $display("FAIL overlap_read5 got %0d want 105", bus.rd_q); else passed++;
  endtask

  task automatic test_overflow();
    write_words(0, DEPTH - 1, 2, 1);
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL ovf_not_ready got %b want 0", bus.wr_ready); else passed++;
    total++; if (bus.err_overflow !== 1'b0) $display("FAIL ovf_before got %b want 0", bus.err_overflow); else passed++;
    step(0, 1, 3, 16'hDEAD, 0, 0, 0, 0);
    total++; if (bus.err_overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.err_overflow); else passed++;
    for (int i = 0; i < 5; i++) idle();
    step(0, 0, 0, '0, 0, 1, 0, 0);
    idle();
    step(0, 0, 0, '0, 0, 0, 1, 3);
    total++; if (bus.rd_q !== m_mem[0][3] || bus.rd_q === 16'hDEAD)
      $display("FAIL ovf_mem_kept got %0h want %0h", bus.rd_q, m_mem[0][3]); else passed++;
    total++; if (bus.err_overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.err_overflow); else passed++;
  endtask

  task automatic test_protocol();
    bit seen = 0;
    step(0, 0, 0, '0, 0, 1, 0, 0);
    total++; if (bus.err_protocol !== 1'b0) $display("FAIL prot_legit_done got %b want 0", bus.err_protocol); else passed++;
    step(0, 0, 0, '0, 0, 1, 0, 0);
    total++; if (bus.err_protocol !== 1'b1) $display("FAIL prot_set got %b want 1", bus.err_protocol); else passed++;
    total++; if (bus.frames_done !== 16'd3) $display("FAIL prot_frames got %0d want 3", bus.frames_done); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (bus.dense_start !== 1'b0) seen = 1;
      idle();
    end
    total++; if (seen) $display("FAIL prot_no_start got 1 want 0"); else passed++;
  endtask

  task automatic test_simultaneous();
    int ra;
    step(1, 0, 0, '0, 0, 0, 0, 0);
    write_words(0, DEPTH - 1, 2, 1);
    idle();
    write_words(0, DEPTH - 2, 2, 0);
    step(0, 1, DEPTH - 1, gen(2, 0), 1, 1, 0, 0);
    total++; if (bus.frames_done !== 16'd1) $display("FAIL sim_frames got %0d want 1", bus.frames_done); else passed++;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL sim_bank0_empty got %b want 1", bus.wr_ready); else passed++;
    total++; if (bus.dense_start !== 1'b0) $display("FAIL sim_start_early got %b want 0", bus.dense_start); else passed++;
    ra = $urandom_range(0, DEPTH - 1);
    step(0, 0, 0, '0, 0, 0, 1, ra);
    total++; if (bus.dense_start !== 1'b1) $display("FAIL sim_start got %b want 1", bus.dense_start); else passed++;
    total++; if (bus.rd_q !== m_mem[1][ra]) $display("FAIL sim_read got %0h want %0h", bus.rd_q, m_mem[1][ra]); else passed++;
  endtask

  task automatic test_reset_midframe();
    bit seen = 0;
    write_words(0, 699, 2, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", bus.wr_ready); else passed++;
    total++; if (bus.dense_start !== 1'b0) $display("FAIL rstmid_start got %b want 0", bus.dense_start); else passed++;
    total++; if (bus.frames_done !== 16'd0) $display("FAIL rstmid_frames got %0d want 0", bus.frames_done); else passed++;
    step(0, 0, 0, '0, 0, 1, 0, 0);
    total++; if (bus.err_protocol !== 1'b1) $display("FAIL rstmid_stale_done got %b want 1", bus.err_protocol); else passed++;
    write_words(0, DEPTH - 1, 0, 1);
    for (int c = 0; c < 10 && !seen; c++) begin
      idle();
      if (bus.dense_start === 1'b1) seen = 1;
    end
    total++; if (!seen) $display("FAIL rstmid_start_timeout got none want pulse"); else passed++;
    step(0, 0, 0, '0, 0, 0, 1, 700);
    total++; if (bus.rd_q !== 16'd700) $display("FAIL rstmid_read got %0d want 700", bus.rd_q); else passed++;
    step(0, 0, 0, '0, 0, 1, 0, 0);
    total++; if (bus.frames_done !== 16'd1) $display("FAIL rstmid_done got %0d want 1", bus.frames_done); else passed++;
  endtask

  task automatic test_random();
    int p = 0;
    int cyc = 0;
    int cnt = 0;
    bit busy = 0;
    int errs = 0;
    step(1, 0, 0, '0, 0, 0, 0, 0);
    while (m_frames < 16'd4 && cyc < 30000) begin
      bit wen = 0, wlast = 0, done = 0, ren;
      int waddr = 0, raddr, r;
      logic [DW-1:0] wdata = '0;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        wen = 1; waddr = $urandom_range(DEPTH, 2047);
      end else if (m_occ < 2) begin
        if (r < 750) begin
          wen = 1; waddr = p; wdata = DW'($urandom); wlast = (p == DEPTH - 1);
          p = wlast ? 0 : p + 1;
        end
      end else if (r < 20) begin
        wen = 1; waddr = $urandom_range(0, DEPTH - 1);
      end
      if (busy) begin
        if (cnt == 0) begin done = 1; busy = 0; end else cnt--;
      end else if ($urandom_range(0, 499) == 0) begin
        done = 1;
      end
      ren = $urandom_range(0, 1);
      raddr = $urandom_range(0, 2047);
      step(0, wen, waddr, wdata, wlast, done, ren, raddr);
      if (bus.dense_start === 1'b1) begin busy = 1; cnt = $urandom_range(0, 3000); end
      total++; if (bus.wr_ready !== (m_occ < 2)) begin errs++; if (errs < 10) $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, bus.wr_ready, m_occ < 2); end else passed++;
      total++; if (bus.dense_start !== m_start) begin errs++; if (errs < 10) $display("FAIL rnd_start cyc %0d got %b want %b", cyc, bus.dense_start, m_start); end else passed++;
      total++; if (bus.rd_q !== m_rd) begin errs++; if (errs < 10) $display("FAIL rnd_rd_q cyc %0d got %0h want %0h", cyc, bus.rd_q, m_rd); end else passed++;
      total++; if (bus.frames_done !== m_frames) begin errs++; if (errs < 10) $display("FAIL rnd_frames cyc %0d got %0d want %0d", cyc, bus.frames_done, m_frames); end else passed++;
      total++; if ({bus.err_overflow, bus.err_protocol} !== {m_ovf, m_prot}) begin errs++;
        if (errs < 10) $display("FAIL rnd_errors cyc %0d got %b want %b", cyc, {bus.err_overflow, bus.err_protocol}, {m_ovf, m_prot}); end else passed++;
      cyc++;
    end
    total++; if (bus.frames_done !== 16'd4) $display("FAIL rnd_progress got %0d want 4", bus.frames_done); else passed++;
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 0;
    bus.dense_done = 0; bus.rd_en = 0; bus.rd_addr = '0;
    test_reset();
    test_fill_and_start();
    test_overlap();
    test_overflow();
    test_protocol();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fc_pingpong_ctrl.md
Name: fc_pingpong_ctrl

Overview:
- Double-buffered feature store and scheduler between the flatten/pool stage (writer) and the fully-connected layer (reader).
- Writer fills one bank while the dense layer reads the other.
- Decides when to pulse the dense layer's start and frees a bank on its done.
- Gives the dense layer a read port with 1-cycle read latency, so the pool stage and fc layer overlap frame-to-frame.

Parameters:
- DATA_WIDTH, 16, feature word width (signed, Q-format opaque to this block).
- DEPTH, 1568, words per frame/bank; AW = max(1, clog2(DEPTH)) is derived, not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  writer word strobe.
- wr_addr  in  AW  word address within the current write bank.
- wr_data  in  DATA_WIDTH  feature word.
- wr_last  in  1  qualifies wr_en: final word of the frame.
- wr_ready  out  1  a bank is available to the writer.
- dense_start  out  1  one-cycle start pulse to the dense layer.
- dense_done  in  1  one-cycle done pulse from the dense layer.
- rd_en  in  1  dense read enable.
- rd_addr  in  AW  dense read address.
- rd_q  out  DATA_WIDTH  read data to the dense layer.
- frames_done  out  16  count of frames consumed by the dense layer, wraps.
- err_overflow  out  1  sticky: write rejected.
- err_protocol  out  1  sticky: unexpected dense_done.

Behaviour:
- Bank state per bank (2 banks): EMPTY, FILLING, FULL, READING. Pointers wbank and rbank are 1 bit each.
- Reset: both banks EMPTY, wbank=rbank=0, reader FSM R_IDLE.
  - Reset values: dense_start=0, rd_q=0, frames_done=0, err_overflow=0, err_protocol=0.
  - wr_ready=1, since it is derived combinationally from state.
  - Memory contents are not cleared.
  - Reset mid-frame discards all bank ownership; a dense layer still running is not aborted, and its later dense_done sets err_protocol.
- wr_ready = bank[wbank] is EMPTY or FILLING.
- Write accept = wr_en && wr_ready && wr_addr < DEPTH.
  - On accept: mem[wbank][wr_addr] <= wr_data, and bank[wbank] becomes FILLING if EMPTY.
  - If wr_last is also set: bank[wbank] becomes FULL and wbank toggles on the same edge.
- wr_en with wr_ready=0, or with wr_addr >= DEPTH: no write, no state change, err_overflow <= 1.
- Writes need not be sequential. The frame is complete only on wr_last.
- Reader FSM has two states, R_IDLE and R_WAIT.
  - In R_IDLE with bank[rbank]==FULL: on that edge, bank[rbank] becomes READING, dense_start is registered high for exactly one cycle, and state goes to R_WAIT.
  - In R_WAIT with dense_done: bank[rbank] becomes EMPTY, rbank toggles, frames_done increments, and state goes to R_IDLE.
  - The next dense_start is therefore no earlier than 2 cycles after dense_done.
- dense_done in R_IDLE: ignored, err_protocol <= 1.
- Read port: if rd_en, rd_q <= mem[rbank][rd_addr] on the next edge (1-cycle latency); otherwise rd_q holds.
  - rd_addr >= DEPTH: rd_q <= 0.
  - Reads are served from rbank regardless of FSM state.
- Simultaneous events:
  - Writer wr_last into bank X together with dense_done freeing bank Y: both take effect on the same edge.
  - A bank freed by dense_done is writable (wr_ready=1) on the following cycle.
  - A bank completed by wr_last is startable on the following cycle.
  - Write and read never target the same bank, because ownership is exclusive.
- Both banks FULL/READING: wr_ready=0 until dense_done.
- Memory: two DATA_WIDTH x DEPTH block-RAM arrays, or one 2*DEPTH array addressed {bank, addr}. Each has one sync write port and one sync read port.

Test Plan:
- Reset, then write frame 0 with words 0..1567 = addr value, wr_last on addr 1567.
  - Response: dense_start pulses exactly 1 cycle, 1 cycle after the wr_last edge.
  - rd_en at addr 5 gives rd_q=5 on the next cycle.
- Write frame 1 (data = addr+100) while the dense layer is in R_WAIT on frame 0.
  - wr_ready stays 1 throughout; after wr_last, wr_ready=0.
  - dense_done then gives wr_ready=1 the next cycle and dense_start for frame 1 the cycle after that.
  - Read at addr 5 returns 105.
- Both banks full, then wr_en pulses at addr 3.
  - Response: no memory change, err_overflow=1 and stays 1 until reset.
- dense_done pulsed in R_IDLE.
  - Response: err_protocol=1, frames_done unchanged, no dense_start.
- Same-cycle wr_last (bank 1) and dense_done (bank 0).
  - Response: bank 0 EMPTY, bank 1 FULL, dense_start for bank 1 two cycles later, frames_done=1.
- Reset asserted at write word 700 of frame 0.
  - Response: the next cycle shows wr_ready=1, dense_start=0, frames_done=0, and both banks EMPTY.
  - A subsequent full frame is processed normally.
